// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg
// Shared definitions for the MAC feeder:
//   - default lane width, slice geometry and slice index width
//   - encoding of the frame control states
//   - helper giving the number of serial bytes in one complete frame
package mac_feeder_pkg;

  localparam int BYTE_W      = 8;
  localparam int SLICE_BYTES = 6;
  localparam int NUM_SLICES  = 62;
  localparam int SLICE_IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Total data_en cycles in a gap-free frame.
  function automatic int frame_bytes(input int slice_bytes, input int num_slices);
    return slice_bytes * num_slices;
  endfunction

endpackage

// File: rtl/mac_feeder_if.sv
// mac_feeder_if
// Parallel slice handshake between the slice producer and the MAC feeder.
//   in_valid : producer has a valid X/W slice pair on x_vec/w_vec
//   in_ready : feeder takes the slice on this cycle's rising edge
//   x_vec    : activation slice, byte 0 in the least significant lane
//   w_vec    : weight slice, same packing
// master = slice producer, slave = feeder.
interface mac_feeder_if #(
  parameter int BYTE_W      = mac_feeder_pkg::BYTE_W,
  parameter int SLICE_BYTES = mac_feeder_pkg::SLICE_BYTES
);

  logic                          in_valid;
  logic                          in_ready;
  logic [SLICE_BYTES*BYTE_W-1:0] x_vec;
  logic [SLICE_BYTES*BYTE_W-1:0] w_vec;

  modport master (
    output in_valid,
    output x_vec,
    output w_vec,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  x_vec,
    input  w_vec,
    output in_ready
  );

endinterface

// File: rtl/mac_feeder_slice_serializer.sv
// mac_feeder_slice_serializer
// Shift buffer for one paired X/W slice. A load captures both vectors;
// every following cycle with valid high presents the low byte of each and
// shifts right by one lane. The buffer empties itself after the final byte
// unless a new load arrives on that same edge.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   flush           : empty the buffer (frame restart)
//   load            : capture load_x/load_w on this edge
//   load_x, load_w  : parallel slice vectors
//   valid           : buffer holds a byte for the current cycle
//   x_byte, w_byte  : current serial bytes, zero while empty
//   last            : current byte is the final byte of the slice
module mac_feeder_slice_serializer #(
  parameter int BYTE_W      = 8,
  parameter int SLICE_BYTES = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          load,
  input  logic [SLICE_BYTES*BYTE_W-1:0] load_x,
  input  logic [SLICE_BYTES*BYTE_W-1:0] load_w,
  output logic                          valid,
  output logic [BYTE_W-1:0]             x_byte,
  output logic [BYTE_W-1:0]             w_byte,
  output logic                          last
);

  localparam int CNT_W = (SLICE_BYTES > 1) ? $clog2(SLICE_BYTES) : 1;

  logic [SLICE_BYTES*BYTE_W-1:0] shift_x;
  logic [SLICE_BYTES*BYTE_W-1:0] shift_w;
  logic [CNT_W-1:0]              byte_cnt;

  assign last   = valid && (byte_cnt == CNT_W'(SLICE_BYTES - 1));
  assign x_byte = valid ? shift_x[BYTE_W-1:0] : '0;
  assign w_byte = valid ? shift_w[BYTE_W-1:0] : '0;

  // A load wins over shifting: the top only loads while the buffer is empty
  // or on its last byte, so the old contents are already fully consumed.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid    <= 1'b0;
      byte_cnt <= '0;
      shift_x  <= '0;
      shift_w  <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      byte_cnt <= '0;
      shift_x  <= load_x;
      shift_w  <= load_w;
    end else if (valid) begin
      shift_x <= shift_x >> BYTE_W;
      shift_w <= shift_w >> BYTE_W;
      if (last) begin
        valid    <= 1'b0;
        byte_cnt <= '0;
      end else begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder
// Feeds the MAC unit: takes parallel X/W slice pairs over a valid/ready
// handshake and streams them out one byte pair per cycle. A pending buffer
// in front of the shift buffer lets the next slice wait while the current
// one drains, so back-to-back slices stream without idle cycles. A frame is
// NUM_SLICES slices; any output gap after the first slice sets underrun.
// Ports:
//   layer_clk  : clock
//   rst        : synchronous active-high reset
//   start      : one-cycle pulse, starts a frame when idle
//   bus        : slice handshake (in_valid, in_ready, x_vec, w_vec)
//   data_en    : x/w carry a valid byte
//   x, w       : serial activation / weight bytes
//   slice_idx  : index of the slice currently on x/w
//   busy       : frame in progress
//   frame_done : one-cycle pulse after the final byte
//   underrun   : sticky starvation flag, cleared by the next start
module mac_feeder #(
  parameter int BYTE_W      = mac_feeder_pkg::BYTE_W,
  parameter int SLICE_BYTES = mac_feeder_pkg::SLICE_BYTES,
  parameter int NUM_SLICES  = mac_feeder_pkg::NUM_SLICES,
  parameter int SLICE_IDX_W = mac_feeder_pkg::SLICE_IDX_W
) (
  input  logic                   layer_clk,
  input  logic                   rst,
  input  logic                   start,
  mac_feeder_if.slave            bus,
  output logic                   data_en,
  output logic [BYTE_W-1:0]      x,
  output logic [BYTE_W-1:0]      w,
  output logic [SLICE_IDX_W-1:0] slice_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   underrun
);

  import mac_feeder_pkg::*;

  localparam int VEC_W = SLICE_BYTES * BYTE_W;
  localparam int ACC_W = $clog2(NUM_SLICES + 1);

  state_t                 state;
  state_t                 next_state;

  logic                   pend_valid;
  logic [VEC_W-1:0]       pend_x;
  logic [VEC_W-1:0]       pend_w;

  logic [SLICE_IDX_W-1:0] slice_cnt;
  logic [ACC_W-1:0]       acc_cnt;

  logic                   shift_valid;
  logic                   shift_last;
  logic                   start_frame;
  logic                   accept;
  logic                   transfer;
  logic                   frame_end;

  assign start_frame = (state == IDLE) && start;
  assign accept      = bus.in_valid && bus.in_ready;
  // in_ready needs an empty pending buffer, so accept and transfer are
  // never both true in the same cycle.
  assign transfer    = pend_valid && (!shift_valid || shift_last);
  assign frame_end   = shift_last && (slice_cnt == SLICE_IDX_W'(NUM_SLICES - 1));

  mac_feeder_slice_serializer #(
    .BYTE_W      (BYTE_W),
    .SLICE_BYTES (SLICE_BYTES)
  ) u_serializer (
    .clk    (layer_clk),
    .rst    (rst),
    .flush  (start_frame),
    .load   (transfer),
    .load_x (pend_x),
    .load_w (pend_w),
    .valid  (shift_valid),
    .x_byte (x),
    .w_byte (w),
    .last   (shift_last)
  );

  assign data_en   = shift_valid;
  assign slice_idx = slice_cnt;

  // Frame state register.
  always_ff @(posedge layer_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: start only matters in IDLE, RUN ends on the edge that
  // emits the final byte of the final slice, DONE lasts exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (frame_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State-derived outputs; in_ready deliberately ignores in_valid.
  always_comb begin
    busy         = (state != IDLE);
    frame_done   = (state == DONE);
    bus.in_ready = (state == RUN) && !pend_valid && (acc_cnt < ACC_W'(NUM_SLICES));
  end

  // Pending buffer: holds the next slice until the shift buffer can take it.
  always_ff @(posedge layer_clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_w     <= '0;
    end else if (start_frame) begin
      pend_valid <= 1'b0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_x     <= bus.x_vec;
      pend_w     <= bus.w_vec;
    end else if (transfer) begin
      pend_valid <= 1'b0;
    end
  end

  // Slice counter advances as each slice finishes, wrapping at frame end;
  // the accept counter stops in_ready once a full frame has been taken.
  always_ff @(posedge layer_clk) begin
    if (rst || start_frame) begin
      slice_cnt <= '0;
      acc_cnt   <= '0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + 1'b1;
      end
      if (shift_last) begin
        if (slice_cnt == SLICE_IDX_W'(NUM_SLICES - 1)) begin
          slice_cnt <= '0;
        end else begin
          slice_cnt <= slice_cnt + 1'b1;
        end
      end
    end
  end

  // Starvation flag: both buffers empty after at least one slice has gone
  // out. A nonzero slice counter in RUN means a slice has been emitted.
  always_ff @(posedge layer_clk) begin
    if (rst || start_frame) begin
      underrun <= 1'b0;
    end else if ((state == RUN) && !shift_valid && !pend_valid && (slice_cnt != '0)) begin
      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
// Directed bench for mac_feeder: a cycle table for reset and the first
// slice handover, then whole frames driven from a slice generator and
// checked byte-by-byte against an independent stream model.
module tb_mac_feeder;

  localparam int NSL          = 62;
  localparam int FRAME_LEN    = 372;
  localparam int FRAME_BUDGET = 1000;
  localparam int STARVE_AT    = 11;

  logic       layer_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       data_en;
  logic [7:0] x;
  logic [7:0] w;
  logic [5:0] slice_idx;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  mac_feeder_if bus ();

  mac_feeder dut (
    .layer_clk  (layer_clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .data_en    (data_en),
    .x          (x),
    .w          (w),
    .slice_idx  (slice_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 layer_clk = ~layer_clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        in_valid;
    int          slice;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs [12];

  // Slice s, byte b: x = s*16+b+1, w = s*16+b+7 (slice 0 -> 01..06 / 07..0C).
  function automatic logic [7:0] model_x(input int s, input int b);
    return 8'(s * 16 + b + 1);
  endfunction

  function automatic logic [7:0] model_w(input int s, input int b);
    return 8'(s * 16 + b + 7);
  endfunction

  function automatic logic [47:0] slice_x(input int s);
    logic [47:0] v;
    for (int b = 0; b < 6; b++) v[b*8 +: 8] = model_x(s, b);
    return v;
  endfunction

  function automatic logic [47:0] slice_w(input int s);
    logic [47:0] v;
    for (int b = 0; b < 6; b++) v[b*8 +: 8] = model_w(s, b);
    return v;
  endfunction

  function automatic logic [63:0] pack_exp(input logic rdy, input logic en,
                                           input logic [7:0] xv, input logic [7:0] wv,
                                           input logic bsy, input logic [5:0] idx,
                                           input logic fd, input logic ur);
    return 64'({rdy, en, xv, wv, bsy, idx, fd, ur});
  endfunction

  function automatic logic [63:0] pack_act();
    return 64'({bus.in_ready, data_en, x, w, busy, slice_idx, frame_done, underrun});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    start        = v.start;
    bus.in_valid = v.in_valid;
    bus.x_vec    = slice_x(v.slice);
    bus.w_vec    = slice_w(v.slice);
    @(posedge layer_clk);
    #1;
  endtask

  // Runs one frame from IDLE. starve_len: ready cycles with in_valid low
  // once STARVE_AT slices are taken. mid_start_cyc: cycle of a stray start
  // pulse. abort_n: stream byte index at which rst is pulsed (-1 = none).
  task automatic run_frame(input string tag, input int starve_len, input int mid_start_cyc,
                           input int abort_n, input bit exp_gap);
    int n = 0;
    int hs_cyc = -1;
    int first_en = -1;
    int last_en = -1;
    int done_cyc = -1;
    int gaps = 0;
    int oversupply = 0;
    int acc = 0;
    int starve_left = starve_len;
    bit pend;
    bit ur_at_done = 1'b0;

    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_vec    = slice_x(0);
    bus.w_vec    = slice_w(0);
    @(posedge layer_clk);
    #1;
    start = 1'b0;
    checkOutput({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    checkOutput({tag, "_underrun_cleared"}, 64'(underrun), 64'd0);

    for (int cyc = 0; cyc < FRAME_BUDGET; cyc++) begin
      if (frame_done) begin
        done_cyc   = cyc;
        ur_at_done = underrun;
        break;
      end
      if (data_en) begin
        checkOutput($sformatf("%s_byte%0d", tag, n), 64'({x, w, slice_idx}),
                    64'({model_x(n / 6, n % 6), model_w(n / 6, n % 6), 6'(n / 6)}));
        if (n == abort_n) begin
          rst = 1'b1;
          @(posedge layer_clk);
          #1;
          rst          = 1'b0;
          bus.in_valid = 1'b0;
          checkOutput({tag, "_data_en"}, 64'(data_en), 64'd0);
          checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
          checkOutput({tag, "_slice_idx"}, 64'(slice_idx), 64'd0);
          checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
          return;
        end
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        n++;
      end else if (n > 0) begin
        gaps++;
      end
      if (acc >= NSL && bus.in_ready) oversupply++;

      start = (cyc == mid_start_cyc);
      if (acc == STARVE_AT && starve_left > 0) begin
        bus.in_valid = 1'b0;
        if (bus.in_ready) starve_left--;
      end else begin
        bus.in_valid = 1'b1;
        bus.x_vec    = slice_x(acc);
        bus.w_vec    = slice_w(acc);
      end
      pend = bus.in_valid && bus.in_ready;
      if (pend && hs_cyc < 0) hs_cyc = cyc;
      @(posedge layer_clk);
      #1;
      if (pend) acc++;
    end
    start = 1'b0;

    checkOutput({tag, "_frame_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    checkOutput({tag, "_byte_count"}, 64'(n), 64'(FRAME_LEN));
    checkOutput({tag, "_first_latency"}, 64'(first_en - hs_cyc), 64'd2);
    checkOutput({tag, "_done_after_last"}, 64'(done_cyc - last_en), 64'd1);
    checkOutput({tag, "_gap_seen"}, 64'(gaps != 0), 64'(exp_gap));
    checkOutput({tag, "_underrun"}, 64'(ur_at_done), 64'(exp_gap));
    checkOutput({tag, "_ready_after_full"}, 64'(oversupply), 64'd0);
    checkOutput({tag, "_accepted"}, 64'(acc), 64'(NSL));

    // 63rd vector stays on the bus; nothing more may be taken or emitted.
    bus.in_valid = 1'b1;
    bus.x_vec    = slice_x(acc);
    bus.w_vec    = slice_w(acc);
    @(posedge layer_clk);
    #1;
    checkOutput({tag, "_idle_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_idle_frame_done"}, 64'(frame_done), 64'd0);
    checkOutput({tag, "_underrun_sticky"}, 64'(underrun), 64'(exp_gap));
    for (int i = 0; i < 3; i++) begin
      @(posedge layer_clk);
      #1;
      checkOutput($sformatf("%s_post%0d_en_ready", tag, i), 64'({data_en, bus.in_ready}), 64'd0);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_vec    = '0;
    bus.w_vec    = '0;

    //             rst   start in_v  slice  rdy en  x      w      busy idx fd ur
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 0, pack_exp(0, 0, 8'h00, 8'h00, 0, 0, 0, 0)};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 0, pack_exp(1, 0, 8'h00, 8'h00, 1, 0, 0, 0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 0, pack_exp(0, 0, 8'h00, 8'h00, 1, 0, 0, 0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1, pack_exp(1, 1, 8'h01, 8'h07, 1, 0, 0, 0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1, pack_exp(0, 1, 8'h02, 8'h08, 1, 0, 0, 0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2, pack_exp(0, 1, 8'h03, 8'h09, 1, 0, 0, 0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 2, pack_exp(0, 1, 8'h04, 8'h0A, 1, 0, 0, 0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2, pack_exp(0, 1, 8'h05, 8'h0B, 1, 0, 0, 0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2, pack_exp(0, 1, 8'h06, 8'h0C, 1, 0, 0, 0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2, pack_exp(1, 1, 8'h11, 8'h17, 1, 1, 0, 0)};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 2, pack_exp(0, 0, 8'h00, 8'h00, 0, 0, 0, 0)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 2, pack_exp(0, 0, 8'h00, 8'h00, 0, 0, 0, 0)};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), pack_act(), vecs[i].expected);
    end
    rst = 1'b0;

    $display("[TB] reset during slice 3 byte 2");
    run_frame("rst_mid", 0, -1, 20, 1'b0);

    $display("[TB] full frame with stray start pulse");
    run_frame("full", 0, 150, -1, 1'b0);

    $display("[TB] frame with input starvation");
    run_frame("starve", 8, 200, -1, 1'b1);

    $display("[TB] start with no input available");
    bus.in_valid = 1'b0;
    start        = 1'b1;
    @(posedge layer_clk);
    #1;
    start = 1'b0;
    checkOutput("nodata_busy", 64'(busy), 64'd1);
    checkOutput("nodata_underrun_cleared", 64'(underrun), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge layer_clk);
      #1;
      checkOutput($sformatf("nodata%0d_busy_en_ur", i), 64'({busy, data_en, underrun}), 64'b100);
    end

    rst = 1'b1;
    @(posedge layer_clk);
    #1;
    rst = 1'b0;
    checkOutput("final_reset", pack_act(), pack_exp(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
